// File: rtl/vdf_seq_pkg.sv
// Shared types and helpers for the VDF squaring sequencer: widths, state enum,
// and expansion of a packed modulus-width value into 32-bit coefficient form.
package vdf_seq_pkg;

  localparam int MOD_LEN      = 1024;
  localparam int WORD_LEN     = 16;
  localparam int NUM_ELEMENTS = MOD_LEN / WORD_LEN + 1;
  localparam int COEFF_W      = 2 * WORD_LEN;
  localparam int SQ_OUT_BITS  = NUM_ELEMENTS * COEFF_W;
  localparam int CKPT_SHIFT   = 20;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_FLUSH = 3'd4
  } seq_state_t;

  // Each WORD_LEN word lands zero-extended in its own coefficient; the top
  // (redundant) coefficient stays zero.
  function automatic logic [SQ_OUT_BITS-1:0] coeff_expand(input logic [MOD_LEN-1:0] x);
    logic [SQ_OUT_BITS-1:0] y;
    y = '0;
    for (int i = 0; i < NUM_ELEMENTS - 1; i++) begin
      y[i*COEFF_W +: COEFF_W] = {{WORD_LEN{1'b0}}, x[i*WORD_LEN +: WORD_LEN]};
    end
    return y;
  endfunction

endpackage

// File: rtl/vdf_seq_watchdog.sv
// Idle-cycle watchdog: counts cycles since the last kick, saturates once it
// reaches TIMEOUT_CYC and reports expiry until cleared or kicked.
module vdf_seq_watchdog #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic kick,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] idle_cnt;

  assign expired = (idle_cnt == CW'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt <= '0;
    end else if (clear || kick) begin
      idle_cnt <= '0;
    end else if (!expired) begin
      idle_cnt <= idle_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/vdf_square_sequencer.sv
// Drives one VDF evaluation through the pipelined squarer: start, count, capture
// the T-th square, hand it out, then flush. Optional VDF_SQ_CHECKPOINT_EN adds checkpoints.
module vdf_square_sequencer
  import vdf_seq_pkg::*;
#(
  parameter int ITER_W      = 64,
  parameter int TIMEOUT_CYC = 256,
  parameter int FLUSH_CYC   = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [MOD_LEN-1:0]     cmd_x,
  input  logic [ITER_W-1:0]      cmd_t,
  input  logic                   abort,
  output logic                   msu_reset,
  output logic                   msu_start,
  output logic [MOD_LEN-1:0]     msu_sq_in,
  input  logic [SQ_OUT_BITS-1:0] msu_sq_out,
  input  logic                   msu_valid,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [SQ_OUT_BITS-1:0] res_data,
  output logic                   busy,
  output logic [ITER_W-1:0]      iter_count,
  output logic                   err_timeout,
`ifdef VDF_SQ_CHECKPOINT_EN
  output logic                   ckpt_valid,
  output logic [SQ_OUT_BITS-1:0] ckpt_data,
`endif
  output seq_state_t             dbg_state
);

  localparam int FW = $clog2(FLUSH_CYC + 1);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready;
  // res_valid/res_data stay stable until that edge and never depend on res_ready.
  seq_state_t        state, state_next;
  logic [ITER_W-1:0] t_reg;
  logic              t_zero;
  logic [FW-1:0]     flush_cnt;
  logic [ITER_W-1:0] iter_inc, iter_new;
  logic              final_hit, wd_expired;
  logic              accept, count_en, capture, wd_fire;

  assign iter_inc  = iter_count + ITER_W'(1);
  assign iter_new  = (iter_count == '1) ? iter_count : iter_inc;
  assign final_hit = (iter_count != '1) && (iter_inc == t_reg);

  assign cmd_ready = (state == S_IDLE);
  assign msu_start = (state == S_START);
  assign res_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  vdf_seq_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state != S_RUN),
    .kick    (msu_valid),
    .expired (wd_expired)
  );

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    count_en   = 1'b0;
    capture    = 1'b0;
    wd_fire    = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          accept     = 1'b1;
          state_next = (cmd_t == '0) ? S_DONE : S_START;
        end
      end
      S_START: state_next = abort ? S_FLUSH : S_RUN;
      S_RUN: begin
        // Abort takes priority even over the final squaring in the same cycle.
        if (abort) begin
          state_next = S_FLUSH;
        end else if (msu_valid) begin
          count_en = 1'b1;
          if (final_hit) begin
            capture    = 1'b1;
            state_next = S_DONE;
          end
        end else if (wd_expired) begin
          wd_fire    = 1'b1;
          state_next = S_FLUSH;
        end
      end
      S_DONE: begin
        if (res_ready) state_next = t_zero ? S_IDLE : S_FLUSH;
      end
      S_FLUSH: begin
        if (flush_cnt == FW'(FLUSH_CYC - 1)) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      t_reg       <= '0;
      t_zero      <= 1'b0;
      iter_count  <= '0;
      err_timeout <= 1'b0;
      res_data    <= '0;
      msu_sq_in   <= '0;
      flush_cnt   <= '0;
      msu_reset   <= 1'b1;
    end else begin
      state     <= state_next;
      // Registered so the squarer sees reset exactly while we sit in FLUSH.
      msu_reset <= (state_next == S_FLUSH);
      flush_cnt <= (state == S_FLUSH) ? flush_cnt + FW'(1) : '0;
      if (accept) begin
        msu_sq_in   <= cmd_x;
        t_reg       <= cmd_t;
        t_zero      <= (cmd_t == '0);
        iter_count  <= '0;
        err_timeout <= 1'b0;
        if (cmd_t == '0) res_data <= coeff_expand(cmd_x);
      end
      if (count_en) iter_count <= iter_new;
      if (capture) res_data <= msu_sq_out;
      if (wd_fire) err_timeout <= 1'b1;
    end
  end

`ifdef VDF_SQ_CHECKPOINT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ckpt_valid <= 1'b0;
      ckpt_data  <= '0;
    end else begin
      ckpt_valid <= count_en && (iter_new[CKPT_SHIFT-1:0] == '0) && !final_hit;
      if (count_en) ckpt_data <= msu_sq_out;
    end
  end
`endif

endmodule

// File: tb/tb_vdf_square_sequencer.sv
// Directed bench for vdf_square_sequencer: vector table for full evaluations
// plus hand-written sequences for hold, abort, timeout and async reset.
module tb_vdf_square_sequencer;
  import vdf_seq_pkg::*;

  localparam int SQ = SQ_OUT_BITS;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [MOD_LEN-1:0] cmd_x = '0;
  logic [63:0]      cmd_t = '0;
  logic             abort = 1'b0;
  logic             msu_reset, msu_start;
  logic [MOD_LEN-1:0] msu_sq_in;
  logic [SQ-1:0]    msu_sq_out = '0;
  logic             msu_valid = 1'b0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [SQ-1:0]    res_data;
  logic             busy;
  logic [63:0]      iter_count;
  logic             err_timeout;
  seq_state_t       dbg_state;
`ifdef VDF_SQ_CHECKPOINT_EN
  logic             ckpt_valid;
  logic [SQ-1:0]    ckpt_data;
`endif

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int res_cnt = 0;

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1);
  end

  vdf_square_sequencer dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_t(cmd_t), .abort(abort), .msu_reset(msu_reset),
    .msu_start(msu_start), .msu_sq_in(msu_sq_in), .msu_sq_out(msu_sq_out),
    .msu_valid(msu_valid), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .busy(busy), .iter_count(iter_count),
    .err_timeout(err_timeout),
`ifdef VDF_SQ_CHECKPOINT_EN
    .ckpt_valid(ckpt_valid), .ckpt_data(ckpt_data),
`endif
    .dbg_state(dbg_state)
  );

  // Monitors: count start pulses and cycles with a result offered.
  always @(posedge clk) begin
    if (msu_start) start_cnt <= start_cnt + 1;
    if (res_valid) res_cnt <= res_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  logic [SQ-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_wide(input string name, input logic [SQ-1:0] act, input logic [SQ-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got top=%08h low=%016h expected top=%08h low=%016h",
               name, act[SQ-1 -: 32], act[63:0], exp[SQ-1 -: 32], exp[63:0]);
    end
  endtask

  function automatic logic [SQ-1:0] sq_pat(input int k);
    logic [SQ-1:0] v;
    v = '0;
    v[31:0]      = 32'hA5A5_0000 | 32'(k);
    v[SQ-1 -: 32] = 32'h5A5A_0000 | 32'(k);
    v[1000 +: 16] = 16'(k * 7 + 1);
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [MOD_LEN-1:0] x, input logic [63:0] t);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    chk("cmd_ready_before_send", 64'(cmd_ready), 64'd1);
    cmd_x = x;
    cmd_t = t;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_valid(input int k);
    msu_sq_out = sq_pat(k);
    msu_valid = 1'b1;
    tick();
    msu_valid = 1'b0;
  endtask

  task automatic count_flush(output int n);
    n = 0;
    while (msu_reset && n < 50) begin n++; tick(); end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (dbg_state != S_IDLE && n < budget) begin tick(); n++; end
    chk(name, 64'(dbg_state), 64'(S_IDLE));
  endtask

  typedef struct {
    logic [MOD_LEN-1:0] x;
    logic [63:0]        t;
    logic [SQ-1:0]      exp_res;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input vec_t v);
    int s0, fl;
    s0 = start_cnt;
    res_ready = 1'b0;
    exp_q.push_back(v.exp_res);
    send_cmd(v.x, v.t);
    chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
    chk_wide("msu_sq_in", SQ'(msu_sq_in), SQ'(v.x));
    if (v.t != 0) begin
      tick();
      for (int k = 1; k <= int'(v.t); k++) begin
        chk("no_early_result", 64'(res_valid), 64'd0);
        repeat (k % 3) tick();
        pulse_valid(k);
      end
    end
    chk("res_valid", 64'(res_valid), 64'd1);
    chk_wide("res_data", res_data, exp_q.pop_front());
    chk("iter_count", iter_count, v.t);
    chk("start_pulses", 64'(start_cnt - s0), (v.t != 0) ? 64'd1 : 64'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    count_flush(fl);
    chk("flush_len", 64'(fl), (v.t != 0) ? 64'd8 : 64'd0);
    wait_idle("idle_after_vec", 20);
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [MOD_LEN-1:0] x;
    logic [SQ-1:0]      e;
    int r0, fl, n;

    vecs[0].x = MOD_LEN'(3); vecs[0].t = 64'd1; vecs[0].exp_res = sq_pat(1);
    vecs[1].x = MOD_LEN'(16'h1234); vecs[1].t = 64'd0; vecs[1].exp_res = SQ'(32'h0000_1234);
    x = '0; x[MOD_LEN-1 -: 16] = 16'hBEEF; x[15:0] = 16'hABCD;
    e = '0; e[63*32 +: 32] = 32'h0000_BEEF; e[31:0] = 32'h0000_ABCD;
    vecs[2].x = x; vecs[2].t = 64'd0; vecs[2].exp_res = e;
    vecs[3].x = MOD_LEN'(8'h55); vecs[3].t = 64'd4; vecs[3].exp_res = sq_pat(4);
    e = '0;
    for (int i = 0; i < 64; i++) e[i*32 +: 32] = 32'h0000_FFFF;
    vecs[4].x = '1; vecs[4].t = 64'd0; vecs[4].exp_res = e;

    // Reset values while reset is asserted.
    #1 reset_n = 1'b0;
    #2;
    chk("rst_msu_reset", 64'(msu_reset), 64'd1);
    chk("rst_msu_start", 64'(msu_start), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk_wide("rst_res_data", res_data, '0);
    chk("rst_iter", iter_count, 64'd0);
    chk("rst_err", 64'(err_timeout), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    tick();
    chk("post_rst_msu_reset", 64'(msu_reset), 64'd0);
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // T=5, result held under backpressure; extra pulses and abort ignored in DONE.
    send_cmd(MOD_LEN'(7), 64'd5);
    tick();
    for (int k = 1; k <= 5; k++) pulse_valid(k);
    for (int i = 0; i < 10; i++) begin
      abort = (i == 3);
      if (i % 2 == 1) pulse_valid(50 + i);
      else tick();
    end
    abort = 1'b0;
    chk("hold_state", 64'(dbg_state), 64'(S_DONE));
    chk_wide("hold_res_data", res_data, sq_pat(5));
    chk("hold_iter", iter_count, 64'd5);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    msu_valid = 1'b1;
    msu_sq_out = sq_pat(99);
    count_flush(fl);
    msu_valid = 1'b0;
    chk("hold_flush_len", 64'(fl), 64'd8);
    chk("hold_iter_after_flush", iter_count, 64'd5);
    chk("hold_idle", 64'(dbg_state), 64'(S_IDLE));

    // T=100, abort after 40 squarings.
    r0 = res_cnt;
    send_cmd(MOD_LEN'(11), 64'd100);
    tick();
    for (int k = 1; k <= 40; k++) pulse_valid(k);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_state", 64'(dbg_state), 64'(S_FLUSH));
    chk("abort_iter", iter_count, 64'd40);
    count_flush(fl);
    chk("abort_flush_len", 64'(fl), 64'd8);
    wait_idle("abort_idle", 20);
    chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("abort_no_result", 64'(res_cnt - r0), 64'd0);

    // Abort together with the final msu_valid: abort wins.
    r0 = res_cnt;
    send_cmd(MOD_LEN'(13), 64'd2);
    tick();
    pulse_valid(1);
    abort = 1'b1;
    pulse_valid(2);
    abort = 1'b0;
    chk("abort_final_state", 64'(dbg_state), 64'(S_FLUSH));
    wait_idle("abort_final_idle", 30);
    chk("abort_final_no_result", 64'(res_cnt - r0), 64'd0);

    // T=10, squarer stalls after 3 pulses.
    r0 = res_cnt;
    send_cmd(MOD_LEN'(17), 64'd10);
    tick();
    for (int k = 1; k <= 3; k++) pulse_valid(k);
    repeat (250) tick();
    chk("timeout_not_yet", 64'(err_timeout), 64'd0);
    chk("timeout_still_run", 64'(dbg_state), 64'(S_RUN));
    n = 0;
    while (!err_timeout && n < 20) begin tick(); n++; end
    chk("timeout_err", 64'(err_timeout), 64'd1);
    chk("timeout_state", 64'(dbg_state), 64'(S_FLUSH));
    chk("timeout_iter", iter_count, 64'd3);
    wait_idle("timeout_idle", 20);
    chk("timeout_no_result", 64'(res_cnt - r0), 64'd0);
    chk("timeout_err_sticky", 64'(err_timeout), 64'd1);
    send_cmd(MOD_LEN'(19), 64'd1);
    chk("timeout_err_cleared", 64'(err_timeout), 64'd0);
    tick();
    pulse_valid(7);
    chk_wide("timeout_followup_res", res_data, sq_pat(7));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    wait_idle("followup_idle", 20);

    // Asynchronous reset in the middle of RUN.
    send_cmd(MOD_LEN'(16'hDEAD), 64'd50);
    tick();
    for (int k = 1; k <= 10; k++) pulse_valid(k);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("arst_msu_reset", 64'(msu_reset), 64'd1);
    chk("arst_msu_start", 64'(msu_start), 64'd0);
    chk("arst_res_valid", 64'(res_valid), 64'd0);
    chk_wide("arst_res_data", res_data, '0);
    chk_wide("arst_sq_in", SQ'(msu_sq_in), '0);
    chk("arst_iter", iter_count, 64'd0);
    chk("arst_err", 64'(err_timeout), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    tick();
    run_vec(vecs[3]);

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
